// File: rtl/spi_keys_pkg.sv
// Shared constants and FSM state type for the SPI key-bitmap receiver.
package spi_keys_pkg;

    localparam int NUM_KEYS_DEF    = 61;
    localparam int IDLE_CYCLES_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff (
    input  logic clk_g_i,
    input  logic rstn_g_i,
    input  logic din,
    output logic dout
);

    logic meta;

    always_ff @(posedge clk_g_i or negedge rstn_g_i) begin
        if (!rstn_g_i) begin
            meta <= 1'b0;
            dout <= 1'b0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/spi_keys_rx.sv
// SPI key-bitmap receiver: oversamples SCK/MOSI on clk_g_i, assembles NUM_KEYS-bit frames.
// Optional SPI_KEYS_RX_DEBOUNCE_EN: accept a frame only when it repeats the previous one.
//
// state    | meaning
// ST_IDLE  | no bits held, bit count 0
// ST_SHIFT | 1..NUM_KEYS-1 bits held
// ST_LOAD  | one cycle after frame completion
module spi_keys_rx
    import spi_keys_pkg::*;
#(
    parameter int NUM_KEYS    = NUM_KEYS_DEF,
    parameter int IDLE_CYCLES = IDLE_CYCLES_DEF
) (
    input  logic                clk_g_i,
    input  logic                rstn_g_i,
    input  logic                spi_clk_i,
    input  logic                spi_mosi_i,
    output logic [NUM_KEYS-1:0] keys_o,
    output logic                frame_valid_o,
    output logic                keys_changed_o,
    output logic                frame_err_o
);

    localparam int CNT_W = $clog2(NUM_KEYS + 1);
    localparam int IDL_W = $clog2(IDLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_KEYS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDL_W-1:0] IDLE_MAX = IDL_W'(IDLE_CYCLES);

    logic                sck_s, mosi_s, sck_d, sck_rise;
    rx_state_t           state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [IDL_W-1:0]    idle_cnt_q;
    logic [NUM_KEYS-1:0] shift_q, new_frame;
    logic                timeout, frame_done, frame_abort, accept;

    sync_2ff u_sync_sck (
        .clk_g_i  (clk_g_i),
        .rstn_g_i (rstn_g_i),
        .din      (spi_clk_i),
        .dout     (sck_s)
    );

    sync_2ff u_sync_mosi (
        .clk_g_i  (clk_g_i),
        .rstn_g_i (rstn_g_i),
        .din      (spi_mosi_i),
        .dout     (mosi_s)
    );

    assign sck_rise  = sck_s & ~sck_d;
    assign timeout   = (idle_cnt_q == IDLE_MAX);
    assign new_frame = {shift_q[NUM_KEYS-2:0], mosi_s};

    always_ff @(posedge clk_g_i or negedge rstn_g_i) begin
        if (!rstn_g_i) begin
            sck_d      <= 1'b0;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            idle_cnt_q <= IDLE_MAX;
            shift_q    <= '0;
        end else begin
            sck_d     <= sck_s;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            if (sck_rise) begin
                idle_cnt_q <= '0;
                shift_q    <= new_frame;
            end else if (!timeout) begin
                idle_cnt_q <= idle_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        frame_done  = 1'b0;
        frame_abort = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sck_rise) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = CNT_ONE;
                end
            end
            ST_SHIFT: begin
                if (sck_rise) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CNT_LAST) begin
                        state_d    = ST_LOAD;
                        frame_done = 1'b1;
                    end
                end else if (timeout) begin
                    state_d     = ST_IDLE;
                    bit_cnt_d   = '0;
                    frame_abort = 1'b1;
                end
            end
            ST_LOAD: begin
                // an edge here is already bit 1 of the following frame
                if (sck_rise) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = CNT_ONE;
                end else begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

`ifdef SPI_KEYS_RX_DEBOUNCE_EN
    logic [NUM_KEYS-1:0] cand_q;
    logic                cand_v_q;

    assign accept = frame_done & cand_v_q & (cand_q == new_frame);

    always_ff @(posedge clk_g_i or negedge rstn_g_i) begin
        if (!rstn_g_i) begin
            cand_q   <= '0;
            cand_v_q <= 1'b0;
        end else if (frame_done) begin
            cand_q   <= new_frame;
            cand_v_q <= 1'b1;
        end else if (frame_abort) begin
            cand_v_q <= 1'b0;
        end
    end
`else
    assign accept = frame_done;
`endif

    always_ff @(posedge clk_g_i or negedge rstn_g_i) begin
        if (!rstn_g_i) begin
            keys_o         <= '0;
            frame_valid_o  <= 1'b0;
            keys_changed_o <= 1'b0;
            frame_err_o    <= 1'b0;
        end else begin
            frame_valid_o  <= accept;
            keys_changed_o <= accept && (new_frame != keys_o);
            frame_err_o    <= frame_abort;
            if (accept) begin
                keys_o <= new_frame;
            end
        end
    end

endmodule

// File: tb/tb_spi_keys_rx.sv
// Self-checking bench for spi_keys_rx with a frame-level reference model.
module tb_spi_keys_rx;

    localparam int NK = 61;

    logic          clk_g_i = 1'b0;
    logic          rstn_g_i;
    logic          spi_clk_i;
    logic          spi_mosi_i;
    logic [NK-1:0] keys_o;
    logic          frame_valid_o;
    logic          keys_changed_o;
    logic          frame_err_o;

    spi_keys_rx dut (
        .clk_g_i        (clk_g_i),
        .rstn_g_i       (rstn_g_i),
        .spi_clk_i      (spi_clk_i),
        .spi_mosi_i     (spi_mosi_i),
        .keys_o         (keys_o),
        .frame_valid_o  (frame_valid_o),
        .keys_changed_o (keys_changed_o),
        .frame_err_o    (frame_err_o)
    );

    always #5 clk_g_i = ~clk_g_i;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_rise = 0;
    int valid_cyc = -1;
    int n_valid = 0, n_chg = 0, n_err = 0;
    int m_valid = 0, m_chg = 0, m_err = 0;
    logic [NK-1:0] exp_keys = '0;
    logic [NK-1:0] cand = '0;
    bit            cand_v = 1'b0;
    logic [NK-1:0] got_q[$];
    logic [NK-1:0] exp_q[$];

    always @(posedge clk_g_i) cyc++;

    always @(negedge clk_g_i) begin
        if (rstn_g_i) begin
            if (frame_valid_o) begin
                n_valid++;
                valid_cyc = cyc;
                got_q.push_back(keys_o);
            end
            if (keys_changed_o) n_chg++;
            if (frame_err_o) n_err++;
        end
    end

    function automatic logic [NK-1:0] rand_frame();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[NK-1:0];
    endfunction

    // Reference: what a completed frame should do to the visible outputs.
    function automatic void model_frame(input logic [NK-1:0] f);
        bit upd;
`ifdef SPI_KEYS_RX_DEBOUNCE_EN
        upd    = cand_v && (cand == f);
        cand   = f;
        cand_v = 1'b1;
`else
        upd = 1'b1;
`endif
        if (upd) begin
            m_valid++;
            if (f != exp_keys) m_chg++;
            exp_keys = f;
            exp_q.push_back(f);
        end
    endfunction

    task automatic send_bits(input logic [NK-1:0] v, input int nbits, input int half);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi_i = v[NK-1-i];
            spi_clk_i  = 1'b0;
            repeat (half) @(negedge clk_g_i);
            spi_clk_i = 1'b1;
            last_rise = cyc;
            repeat (half) @(negedge clk_g_i);
        end
    endtask

    task automatic send_frame(input logic [NK-1:0] v, input int half);
        send_bits(v, NK, half);
        model_frame(v);
    endtask

    task automatic do_reset();
        spi_clk_i  = 1'b0;
        spi_mosi_i = 1'b0;
        rstn_g_i   = 1'b0;
        exp_keys   = '0;
        cand_v     = 1'b0;
        repeat (3) @(negedge clk_g_i);
        rstn_g_i = 1'b1;
        repeat (2) @(negedge clk_g_i);
    endtask

    task automatic test_reset();
        spi_clk_i  = 1'b0;
        spi_mosi_i = 1'b0;
        rstn_g_i   = 1'b0;
        #1;
        total++;
        if (keys_o !== '0) begin bad++; $display("FAIL reset_keys got=%h exp=0", keys_o); end
        total++;
        if ({frame_valid_o, keys_changed_o, frame_err_o} !== 3'b000) begin
            bad++; $display("FAIL reset_pulses got=%b exp=000", {frame_valid_o, keys_changed_o, frame_err_o});
        end
        repeat (3) @(negedge clk_g_i);
        rstn_g_i = 1'b1;
        repeat (2) @(negedge clk_g_i);
    endtask

    task automatic test_single();
        logic [NK-1:0] v;
        v = 61'h0F0F_0F0F_0F0F_0F0;
        send_frame(v, 4);
        repeat (6) @(negedge clk_g_i);
        total++;
        if (keys_o !== exp_keys) begin bad++; $display("FAIL single_keys got=%h exp=%h", keys_o, exp_keys); end
        total++;
        if (n_valid !== m_valid) begin bad++; $display("FAIL single_valid got=%0d exp=%0d", n_valid, m_valid); end
        total++;
        if (n_chg !== m_chg) begin bad++; $display("FAIL single_changed got=%0d exp=%0d", n_chg, m_chg); end
`ifndef SPI_KEYS_RX_DEBOUNCE_EN
        // SCK rise -> 2 sync flops -> edge cycle -> registered outputs
        total++;
        if (valid_cyc - last_rise !== 3) begin
            bad++; $display("FAIL single_latency got=%0d exp=3", valid_cyc - last_rise);
        end
`endif
    endtask

    task automatic test_repeat();
        logic [NK-1:0] v;
        v = 61'h0F0F_0F0F_0F0F_0F0;
        repeat (100) @(negedge clk_g_i);
        send_frame(v, 4);
        repeat (6) @(negedge clk_g_i);
        total++;
        if (n_valid !== m_valid) begin bad++; $display("FAIL repeat_valid got=%0d exp=%0d", n_valid, m_valid); end
        total++;
        if (n_chg !== m_chg) begin bad++; $display("FAIL repeat_changed got=%0d exp=%0d", n_chg, m_chg); end
        total++;
        if (n_err !== m_err) begin bad++; $display("FAIL repeat_idle_err got=%0d exp=%0d", n_err, m_err); end
        total++;
        if (keys_o !== exp_keys) begin bad++; $display("FAIL repeat_keys got=%h exp=%h", keys_o, exp_keys); end
    endtask

    task automatic test_abort();
        logic [NK-1:0] v;
        send_bits(rand_frame(), 30, 4);
        repeat (80) @(negedge clk_g_i);
        m_err++;
        cand_v = 1'b0;
        total++;
        if (n_err !== m_err) begin bad++; $display("FAIL abort_err got=%0d exp=%0d", n_err, m_err); end
        total++;
        if (keys_o !== exp_keys) begin bad++; $display("FAIL abort_keys got=%h exp=%h", keys_o, exp_keys); end
        total++;
        if (n_valid !== m_valid) begin bad++; $display("FAIL abort_valid got=%0d exp=%0d", n_valid, m_valid); end
        v = rand_frame() | 61'h1;
        send_frame(v, 4);
        send_frame(v, 4);
        repeat (6) @(negedge clk_g_i);
        total++;
        if (keys_o !== exp_keys) begin bad++; $display("FAIL abort_next_keys got=%h exp=%h", keys_o, exp_keys); end
        total++;
        if (n_valid !== m_valid) begin bad++; $display("FAIL abort_next_valid got=%0d exp=%0d", n_valid, m_valid); end
        total++;
        if (n_err !== m_err) begin bad++; $display("FAIL abort_next_err got=%0d exp=%0d", n_err, m_err); end
    endtask

    task automatic test_random();
        logic [NK-1:0] v, prev;
        prev = exp_keys;
        for (int k = 0; k < 6; k++) begin
            v = ($urandom_range(0, 2) == 0) ? prev : rand_frame();
            send_frame(v, $urandom_range(1, 4));
            prev = v;
            repeat ($urandom_range(0, 20)) @(negedge clk_g_i);
        end
        repeat (6) @(negedge clk_g_i);
        total++;
        if (n_valid !== m_valid) begin bad++; $display("FAIL random_valid got=%0d exp=%0d", n_valid, m_valid); end
        total++;
        if (n_chg !== m_chg) begin bad++; $display("FAIL random_changed got=%0d exp=%0d", n_chg, m_chg); end
        total++;
        if (n_err !== m_err) begin bad++; $display("FAIL random_err got=%0d exp=%0d", n_err, m_err); end
        total++;
        if (keys_o !== exp_keys) begin bad++; $display("FAIL random_keys got=%h exp=%h", keys_o, exp_keys); end
    endtask

    task automatic test_back_to_back();
        logic [NK-1:0] a, b;
        a = rand_frame();
        b = ~a;
        send_frame(a, 1);
        send_frame(b, 1);
        send_frame(b, 2);
        repeat (6) @(negedge clk_g_i);
        total++;
        if (n_valid !== m_valid) begin bad++; $display("FAIL b2b_valid got=%0d exp=%0d", n_valid, m_valid); end
        total++;
        if (keys_o !== exp_keys) begin bad++; $display("FAIL b2b_keys got=%h exp=%h", keys_o, exp_keys); end
        total++;
        if (got_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL b2b_frame_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [NK-1:0] g, e;
            g = got_q.pop_front();
            e = exp_q.pop_front();
            total++;
            if (g !== e) begin bad++; $display("FAIL b2b_bitmap got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_reset_mid();
        logic [NK-1:0] v;
        int err_before;
        send_bits(rand_frame(), 40, 4);
        err_before = n_err;
        rstn_g_i = 1'b0;
        #1;
        total++;
        if (keys_o !== '0) begin bad++; $display("FAIL midrst_keys got=%h exp=0", keys_o); end
        total++;
        if ({frame_valid_o, keys_changed_o, frame_err_o} !== 3'b000) begin
            bad++; $display("FAIL midrst_pulses got=%b exp=000", {frame_valid_o, keys_changed_o, frame_err_o});
        end
        do_reset();
        repeat (100) @(negedge clk_g_i);
        total++;
        if (n_err !== err_before) begin bad++; $display("FAIL midrst_err got=%0d exp=%0d", n_err, err_before); end
        send_frame('0, 3);
        send_frame('0, 3);
        repeat (6) @(negedge clk_g_i);
        total++;
        if (n_valid !== m_valid) begin bad++; $display("FAIL midrst_zero_valid got=%0d exp=%0d", n_valid, m_valid); end
        total++;
        if (n_chg !== m_chg) begin bad++; $display("FAIL midrst_zero_changed got=%0d exp=%0d", n_chg, m_chg); end
        do_reset();
        v = rand_frame() | 61'h100;
        send_frame(v, 4);
        send_frame(v, 4);
        repeat (6) @(negedge clk_g_i);
        total++;
        if (keys_o !== exp_keys) begin bad++; $display("FAIL midrst_keys_after got=%h exp=%h", keys_o, exp_keys); end
        total++;
        if (n_chg !== m_chg) begin bad++; $display("FAIL midrst_changed_after got=%0d exp=%0d", n_chg, m_chg); end
    endtask

`ifdef SPI_KEYS_RX_DEBOUNCE_EN
    task automatic test_debounce();
        logic [NK-1:0] a, b;
        do_reset();
        a = rand_frame() | 61'h1;
        b = a ^ 61'h3;
        send_frame(a, 2);
        send_frame(b, 2);
        repeat (6) @(negedge clk_g_i);
        total++;
        if (keys_o !== '0) begin bad++; $display("FAIL debounce_hold got=%h exp=0", keys_o); end
        send_frame(b, 2);
        repeat (6) @(negedge clk_g_i);
        total++;
        if (keys_o !== b) begin bad++; $display("FAIL debounce_accept got=%h exp=%h", keys_o, b); end
        total++;
        if (n_valid !== m_valid) begin bad++; $display("FAIL debounce_valid got=%0d exp=%0d", n_valid, m_valid); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_repeat();
        test_abort();
        test_random();
        got_q.delete();
        exp_q.delete();
        test_back_to_back();
        test_reset_mid();
`ifdef SPI_KEYS_RX_DEBOUNCE_EN
        test_debounce();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
